alu_main: RTL and testbench
===========================

ALU_MAIN -- requirements
Module: alu_main

Interface
REQ-001 Ports: one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_sel  input  3  mode request {persist, load, clear} = bits [2],[1],[0].
REQ-005 num1  input  8  operand A source in LOAD.
REQ-006 num2  input  8  operand B, all computing states.
REQ-007 out_sel  input  6  one-hot operation select.
REQ-008 out  output  8  accumulator register value.
REQ-009 currState  output  2  registered FSM state.
REQ-010 nextState  output  2  combinational next FSM state.

Function
REQ-011 States SHALL be encoded as: CLEAR=2'b00, LOAD=2'b01, PERSIST=2'b10, HOLD=2'b11.
REQ-012 nextState SHALL be decoded combinationally from in_sel with fixed priority: in_sel[0]=1 -> CLEAR; else in_sel[1]=1 -> LOAD; else in_sel[2]=1 -> PERSIST; else HOLD.
REQ-013 nextState SHALL depend only on in_sel, never on currState, so any state is reachable from any state in one cycle.
REQ-014 On each rising clk edge, currState SHALL load nextState.
REQ-015 On each rising clk edge, the accumulator (out) SHALL update according to the current currState, before the transition takes effect:
 - CLEAR: acc <= 8'h00.
 - LOAD: acc <= f(num1, num2).
 - PERSIST: acc <= f(acc, num2).
 - HOLD: acc unchanged.
REQ-016 f(A,B) SHALL be selected by out_sel, with the lowest set bit winning:
 - bit0: A+B
 - bit1: A-B
 - bit2: A AND B
 - bit3: A OR B
 - bit4: A XOR B
 - bit5: NOT A
REQ-017 out_sel=6'b000000 SHALL give f=A (pass-through).
REQ-018 Arithmetic SHALL be unsigned 8-bit modulo 256; carry and borrow are discarded, with no flags.
REQ-019 Latency: an in_sel change is reflected on nextState combinationally, on currState after 1 edge, and on out after 2 edges.
REQ-020 out SHALL be a pure register output, with no combinational path from num1, num2 or out_sel.
REQ-021 X or Z on in_sel is not a supported operating condition; the design needs no defined behaviour for it.

Reset
REQ-022 While reset is high, currState SHALL be CLEAR and out SHALL be 8'h00, asynchronously and independent of clk.
REQ-023 nextState SHALL continue to follow in_sel during reset.
REQ-024 On the first rising edge after reset deasserts, currState SHALL take nextState, and acc SHALL apply the CLEAR action (stays 8'h00).
REQ-025 Reset asserted mid-operation SHALL abort the current state immediately; no partial result is retained.

Verification
REQ-026 Reset, then in_sel=010, num1=8'h57, num2=8'h1A, and out_sel set in turn to 000001, 000010, 000100, 001000, 010000, 100000 -> out after 2 edges = 71, 3D, 12, 5F, 4D, A8 (hex).
REQ-027 After LOAD gives out=8'h71, in_sel=100, num2=8'h01, out_sel=000001 -> out = 72, 73, 74 on successive edges.
REQ-028 Wrap and underflow: PERSIST ADD with acc=FF, num2=01 -> out=00; PERSIST SUB with acc=00, num2=01 -> out=FF.
REQ-029 Priority and HOLD:
 - in_sel=111 -> nextState=00 and out=00.
 - in_sel=110 -> nextState=01.
 - in_sel=000 -> nextState=11 and out frozen for 10 cycles while num1, num2 and out_sel toggle.
REQ-030 Async reset: assert reset between clock edges while out=8'h5F -> out=00 and currState=00 immediately, with no clk edge.
REQ-031 out_sel=000110 with A=57, B=1A -> SUB result 3D (lowest set bit wins).
REQ-032 out_sel=000000 -> out=num1 in LOAD.

Source files
------------

// File: rtl/alu_main.sv
// ---------------------------------------------------------------------------
// alu_main
//   Mode-driven accumulator.  A small FSM selects each cycle whether the 8-bit
//   accumulator is cleared, loaded from f(num1, num2), updated in place with
//   f(acc, num2), or held.  f is picked by a one-hot operation select, and the
//   lowest set bit wins.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous active-high reset
//   in_sel     in   3  mode request {persist, load, clear}
//   num1       in   8  operand A while in LOAD
//   num2       in   8  operand B in every computing state
//   out_sel    in   6  one-hot operation select (add, sub, and, or, xor, not)
//   out        out  8  accumulator register
//   currState  out  2  registered FSM state
//   nextState  out  2  combinational next FSM state
// ---------------------------------------------------------------------------
module alu_main (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] in_sel,
    input  logic [7:0] num1,
    input  logic [7:0] num2,
    input  logic [5:0] out_sel,
    output logic [7:0] out,
    output logic [1:0] currState,
    output logic [1:0] nextState
);

    typedef enum logic [1:0] {
        CLEAR   = 2'b00,
        LOAD    = 2'b01,
        PERSIST = 2'b10,
        HOLD    = 2'b11
    } state_t;

    state_t     curr_state;
    state_t     next_state;
    logic [7:0] acc;
    logic [7:0] acc_next;

    // Operation select.  The if/else chain gives the lowest set bit priority,
    // so a malformed multi-hot select still yields a single defined result.
    // An all-zero select passes operand A through.  Arithmetic wraps mod 256.
    function automatic logic [7:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [5:0] sel);
        logic [7:0] r;
        if (sel[0])      r = a + b;
        else if (sel[1]) r = a - b;
        else if (sel[2]) r = a & b;
        else if (sel[3]) r = a | b;
        else if (sel[4]) r = a ^ b;
        else if (sel[5]) r = ~a;
        else             r = a;
        return r;
    endfunction

    // State register.  Reset forces CLEAR at once, without waiting for a
    // clock edge, so an in-flight mode is abandoned immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) curr_state <= CLEAR;
        else       curr_state <= next_state;
    end

    // Next-state decode.  It looks only at in_sel, never at the current
    // state, so any mode is one edge away from any other.  It keeps
    // following in_sel while reset is held.
    always_comb begin
        next_state = HOLD;
        if (in_sel[0])      next_state = CLEAR;
        else if (in_sel[1]) next_state = LOAD;
        else if (in_sel[2]) next_state = PERSIST;
    end

    // Accumulator update, chosen by the state the FSM is in now.  A mode
    // request therefore reaches currState after one edge and out after two.
    always_comb begin
        acc_next = acc;
        case (curr_state)
            CLEAR:   acc_next = 8'h00;
            LOAD:    acc_next = alu_f(num1, num2, out_sel);
            PERSIST: acc_next = alu_f(acc, num2, out_sel);
            HOLD:    acc_next = acc;
            default: acc_next = acc;
        endcase
    end

    // Accumulator register.  out comes straight from this flop, so there is
    // no combinational path from the operands or the select to out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= 8'h00;
        else       acc <= acc_next;
    end

    assign out       = acc;
    assign currState = curr_state;
    assign nextState = next_state;

endmodule

// File: tb/tb_alu_main.sv
// ---------------------------------------------------------------------------
// tb_alu_main
//   Directed self-checking bench for alu_main.  The stimulus process drives
//   inputs on the falling edge and queues hand-computed expectations, each
//   tagged with the rising-edge count at which it becomes true.  A separate
//   monitor counts rising edges and, just after each one, pops and checks
//   every expectation that is due.  Combinational and asynchronous behaviour
//   (nextState, reset) is checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_alu_main;

    logic       clk;
    logic       reset;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [5:0] out_sel;
    logic [7:0] out;
    logic [1:0] currState;
    logic [1:0] nextState;

    typedef struct {
        int         due;
        bit         is_state;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cycle    = 0;
    int   testsRun = 0;
    int   failures = 0;

    alu_main dut (
        .clk       (clk),
        .reset     (reset),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the monitor and the direct checks.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic [7:0] a,
                                 input logic [7:0] b, input logic [5:0] op);
        in_sel  = s;
        num1    = a;
        num2    = b;
        out_sel = op;
    endtask

    // Queue an expectation that becomes true 'edges' rising edges from now.
    // Callers push in non-decreasing order of due edge.
    task automatic expectOut(input int edges, input logic [7:0] v, input string name);
        exp_t e;
        e.due = cycle + edges; e.is_state = 1'b0; e.val = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic expectState(input int edges, input logic [1:0] v, input string name);
        exp_t e;
        e.due = cycle + edges; e.is_state = 1'b1; e.val = {6'b0, v}; e.name = name;
        q.push_back(e);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: after each rising edge, check everything that has come due.
    always @(posedge clk) begin
        exp_t e;
        cycle++;
        #1;
        while (q.size() > 0 && q[0].due <= cycle) begin
            e = q.pop_front();
            if (e.is_state) checkOutput(e.name, {6'b0, currState}, e.val);
            else            checkOutput(e.name, out, e.val);
        end
    end

    logic [5:0] opTab [6] = '{6'b000001, 6'b000010, 6'b000100,
                              6'b001000, 6'b010000, 6'b100000};
    logic [7:0] resTab[6] = '{8'h71, 8'h3D, 8'h12, 8'h5F, 8'h4D, 8'hA8};

    initial begin
        reset = 1'b1;
        applyStimulus(3'b001, 8'h00, 8'h00, 6'b000000);

        // Reset state, including across a clock edge while reset is held.
        waitEdges(2);
        checkOutput("reset_out", out, 8'h00);
        checkOutput("reset_state", {6'b0, currState}, 8'h00);
        applyStimulus(3'b010, 8'h57, 8'h1A, opTab[0]);
        #1 checkOutput("reset_next_follows", {6'b0, nextState}, 8'h01);

        // Release reset into LOAD: first edge applies CLEAR, second computes.
        @(negedge clk);
        reset = 1'b0;
        expectState(1, 2'b01, "load_state");
        expectOut(1, 8'h00, "post_reset_clear");
        expectOut(2, resTab[0], "load_add");
        waitEdges(2);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(3'b010, 8'h57, 8'h1A, opTab[i]);
            expectOut(1, resTab[i], $sformatf("load_op%0d", i));
            waitEdges(1);
        end

        // Lowest set bit wins; an empty select passes num1 through.
        applyStimulus(3'b010, 8'h57, 8'h1A, 6'b000110);
        expectOut(1, 8'h3D, "multi_hot_sub");
        waitEdges(1);
        applyStimulus(3'b010, 8'h57, 8'h1A, 6'b000000);
        expectOut(1, 8'h57, "pass_through");
        waitEdges(1);

        // Back to 71, then move to PERSIST and count up by one.
        applyStimulus(3'b010, 8'h57, 8'h1A, 6'b000001);
        expectOut(1, 8'h71, "reload_71");
        waitEdges(1);
        applyStimulus(3'b100, 8'h57, 8'h1A, 6'b000001);
        expectState(1, 2'b10, "persist_state");
        expectOut(1, 8'h71, "persist_entry");
        waitEdges(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b100, 8'h57, 8'h01, 6'b000001);
            expectOut(1, 8'h72 + 8'(i), $sformatf("persist_inc%0d", i));
            waitEdges(1);
        end

        // Wrap on add and underflow on subtract.
        applyStimulus(3'b010, 8'hFF, 8'h01, 6'b000000);
        expectState(1, 2'b01, "wrap_load_state");
        expectOut(2, 8'hFF, "wrap_load_ff");
        waitEdges(2);
        applyStimulus(3'b100, 8'hFF, 8'h01, 6'b000000);
        expectOut(1, 8'hFF, "wrap_persist_entry");
        waitEdges(1);
        applyStimulus(3'b100, 8'hFF, 8'h01, 6'b000001);
        expectOut(1, 8'h00, "wrap_add");
        waitEdges(1);
        applyStimulus(3'b100, 8'hFF, 8'h01, 6'b000010);
        expectOut(1, 8'hFF, "underflow_sub");
        waitEdges(1);

        // Priority: clear beats everything.
        applyStimulus(3'b111, 8'h12, 8'h34, 6'b000001);
        #1 checkOutput("prio_111_next", {6'b0, nextState}, 8'h00);
        expectState(1, 2'b00, "prio_111_state");
        expectOut(2, 8'h00, "prio_111_out");
        waitEdges(2);

        // Load beats persist.
        applyStimulus(3'b110, 8'h3C, 8'h00, 6'b000000);
        #1 checkOutput("prio_110_next", {6'b0, nextState}, 8'h01);
        expectState(1, 2'b01, "prio_110_state");
        waitEdges(1);

        // HOLD freezes out while the operands and select toggle.
        applyStimulus(3'b000, 8'h3C, 8'h00, 6'b000000);
        #1 checkOutput("hold_next", {6'b0, nextState}, 8'h03);
        expectState(1, 2'b11, "hold_state");
        expectOut(1, 8'h3C, "hold_entry");
        waitEdges(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(3'b000, 8'(i * 37 + 5), 8'(i * 91 + 3), 6'(1 << (i % 6)));
            expectOut(1, 8'h3C, $sformatf("hold_frozen%0d", i));
            waitEdges(1);
        end

        // Reach 5F, then assert reset between edges.
        applyStimulus(3'b010, 8'h57, 8'h1A, 6'b001000);
        expectOut(2, 8'h5F, "pre_async_5f");
        waitEdges(2);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_out", out, 8'h00);
        checkOutput("async_state", {6'b0, currState}, 8'h00);
        waitEdges(1);

        // Recovery: first edge applies CLEAR, then the LOAD result appears.
        reset = 1'b0;
        expectState(1, 2'b01, "recover_state");
        expectOut(1, 8'h00, "recover_clear");
        expectOut(2, 8'h5F, "recover_load");
        waitEdges(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) waitEdges(1);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            testsRun++;
            failures++;
            $display("[TB] FAIL %s: never checked, expected %h by cycle %0d",
                     e.name, e.val, e.due);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
